// File: rtl/pa_fmau_pkg.sv
// Shared types and configuration limits for the FMAU pipeline controller.
// Optional counters elsewhere are enabled by FMAU_PIPE_PERF_CNT_EN.
package pa_fmau_pkg;

   localparam int unsigned STAGES_MIN  = 3;
   localparam int unsigned STAGES_MAX  = 6;
   localparam int unsigned MUL_LAT_MIN = 2;
   localparam int unsigned DNORM_MIN   = 1;
   localparam int unsigned DNORM_MAX   = 3;
   localparam int unsigned ID_W_MAX    = 16;

   typedef logic [1:0] dnorm_state_t;
   localparam dnorm_state_t DN_IDLE = 2'd0;
   localparam dnorm_state_t DN_NORM = 2'd1;
   localparam dnorm_state_t DN_DONE = 2'd2;

   typedef struct packed {
      logic                vld;
      logic                mac;
      logic [ID_W_MAX-1:0] id;
   } stage_t;

   function automatic logic cfg_legal(input int unsigned stages, input int unsigned mul_lat,
                                      input int unsigned mac_lat, input int unsigned dnorm_cyc,
                                      input int unsigned id_width);
      return (stages >= STAGES_MIN) && (stages <= STAGES_MAX) &&
             (mul_lat >= MUL_LAT_MIN) && (mul_lat < mac_lat) && (mac_lat <= stages) &&
             (dnorm_cyc >= DNORM_MIN) && (dnorm_cyc <= DNORM_MAX) &&
             (id_width >= 1) && (id_width <= ID_W_MAX);
   endfunction

endpackage

// File: rtl/pa_fmau_dnorm_fsm.sv
// Denormal-normalisation stall sequencer for FMAU ex1 (IDLE -> NORM -> DONE).
module pa_fmau_dnorm_fsm
   import pa_fmau_pkg::*;
#(
   parameter int unsigned DNORM_CYC = 1
)(
   input  logic forever_cpuclk,
   input  logic cpurst_b,
   input  logic sel,
   input  logic denorm,
   input  logic special,
   input  logic cancel,
   input  logic ext_hold,
   output logic denorm_stall
);

   localparam logic [1:0] CNT_INIT = 2'(DNORM_CYC);

   dnorm_state_t state, state_nxt;
   logic [1:0]   cnt, cnt_nxt;

   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      denorm_stall = 1'b0;
      case (state)
         DN_IDLE: begin
            // stall already asserted in the entry cycle so ex1 does not advance
            if (sel & denorm & ~special & ~ext_hold) begin
               denorm_stall = 1'b1;
               state_nxt    = DN_NORM;
               cnt_nxt      = CNT_INIT;
            end
         end
         DN_NORM: begin
            denorm_stall = 1'b1;
            if (cancel) begin
               state_nxt = DN_IDLE;
               cnt_nxt   = '0;
            end else if (~ext_hold) begin
               cnt_nxt = cnt - 2'd1;
               if (cnt == 2'd1) state_nxt = DN_DONE;
            end
         end
         DN_DONE: begin
            if (cancel) begin
               state_nxt = DN_IDLE;
               cnt_nxt   = '0;
            end else if (~ext_hold) begin
               state_nxt = DN_IDLE;
            end
         end
         default: begin
            state_nxt = DN_IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         state <= DN_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

endmodule

// File: rtl/pa_fmau_pipe_ctrl_n.sv
// Parametrised FMAU execute-pipe controller: stage valids/IDs, hold chain, retire arbitration.
// Define FMAU_PIPE_PERF_CNT_EN to add saturating denorm-stall and collision counters.
module pa_fmau_pipe_ctrl_n
   import pa_fmau_pkg::*;
#(
   parameter int unsigned STAGES    = 4,
   parameter int unsigned MUL_LAT   = 3,
   parameter int unsigned MAC_LAT   = 4,
   parameter int unsigned DNORM_CYC = 1,
   parameter int unsigned ID_WIDTH  = 3
)(
   input  logic                forever_cpuclk,
   input  logic                cpurst_b,
   input  logic                ctrl_fmau_ex1_sel,
   input  logic                ex1_mac,
   input  logic                ex1_special,
   input  logic                ex1_denorm,
   input  logic [ID_WIDTH-1:0] ex1_id,
   input  logic                rtu_xx_ex1_cancel,
   input  logic                ctrl_xx_ex2_cancel,
   input  logic [STAGES-1:0]   ctrl_xx_stall,
   output logic                fmau_fpu_ex1_cmplt,
   output logic                fmau_fpu_ex1_denorm_stall,
   output logic [STAGES-1:0]   fmau_pipe_vld,
   output logic [STAGES-1:0]   fmau_pipe_down,
   output logic                fmau_fpu_result_vld,
   output logic                fmau_fpu_result_mac,
   output logic [ID_WIDTH-1:0] fmau_fpu_result_id,
`ifdef FMAU_PIPE_PERF_CNT_EN
   output logic [15:0]         fmau_perf_dnorm_cnt,
   output logic [15:0]         fmau_perf_coll_cnt,
`endif
   output logic                fmau_busy
);

   if (!cfg_legal(STAGES, MUL_LAT, MAC_LAT, DNORM_CYC, ID_WIDTH)) begin : g_bad_cfg
      $error("pa_fmau_pipe_ctrl_n: illegal parameter combination");
   end

   stage_t              cur [STAGES];
   stage_t              st  [1:STAGES-1];
   logic [STAGES-1:0]   vld;
   logic [STAGES:0]     hc;
   logic [STAGES-1:1]   rtr;
   logic [STAGES-1:0]   down;
   logic                coll;
   logic                hold_1;
   logic                dnorm_stall;
   logic                res_vld;
   logic                res_mac;
   logic [ID_W_MAX-1:0] res_id;
   logic                unused_res_id;

   // cur[] is the effective view of every stage: ex1 from inputs, ex2 after cancel
   always_comb begin
      cur[0] = '{vld: cpurst_b & ctrl_fmau_ex1_sel & ~rtu_xx_ex1_cancel,
                 mac: ex1_mac, id: ID_W_MAX'(ex1_id)};
      for (int unsigned i = 1; i < STAGES; i++) cur[i] = st[i];
      cur[1].vld = st[1].vld & ~ctrl_xx_ex2_cancel;
      vld = '0;
      for (int unsigned i = 0; i < STAGES; i++) vld[i] = cur[i].vld;

      hc   = '0;
      coll = 1'b0;
      for (int unsigned i = STAGES; i > 0; i--) begin
         hc[i-1] = ctrl_xx_stall[i-1] | hc[i];
         if (i == MUL_LAT) begin
            coll = vld[MUL_LAT-1] & ~cur[MUL_LAT-1].mac &
                   vld[MAC_LAT-1] &  cur[MAC_LAT-1].mac & ~hc[MAC_LAT-1];
            hc[i-1] = hc[i-1] | coll;
         end
      end

      rtr = '0;
      for (int unsigned i = 1; i < STAGES; i++)
         rtr[i] = vld[i] & ~hc[i] & (cur[i].mac ? (i == MAC_LAT-1) : (i == MUL_LAT-1));
   end

   pa_fmau_dnorm_fsm #(.DNORM_CYC(DNORM_CYC)) u_dnorm (
      .forever_cpuclk (forever_cpuclk),
      .cpurst_b       (cpurst_b),
      .sel            (vld[0]),
      .denorm         (ex1_denorm),
      .special        (ex1_special),
      .cancel         (rtu_xx_ex1_cancel),
      .ext_hold       (hc[0]),
      .denorm_stall   (dnorm_stall)
   );

   assign hold_1 = hc[0] | dnorm_stall;

   always_comb begin
      down    = '0;
      down[0] = vld[0] & ~hold_1 & ~ex1_special;
      for (int unsigned i = 1; i < STAGES; i++) down[i] = vld[i] & ~hc[i] & ~rtr[i];
   end

   always_comb begin
      res_vld = 1'b0;
      res_mac = 1'b0;
      res_id  = '0;
      for (int unsigned i = 1; i < STAGES; i++) begin
         if (rtr[i]) begin
            res_vld = 1'b1;
            res_mac = cur[i].mac;
            res_id  = cur[i].id;
         end
      end
   end

   // an unheld stage always empties (advance or retire) and takes whatever comes down
   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         for (int unsigned i = 1; i < STAGES; i++) st[i] <= '0;
      end else begin
         for (int unsigned i = 1; i < STAGES; i++) begin
            if (hc[i]) st[i].vld <= vld[i];
            else       st[i]     <= '{vld: down[i-1], mac: cur[i-1].mac, id: cur[i-1].id};
         end
      end
   end

`ifdef FMAU_PIPE_PERF_CNT_EN
   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         fmau_perf_dnorm_cnt <= '0;
         fmau_perf_coll_cnt  <= '0;
      end else begin
         if (dnorm_stall && (fmau_perf_dnorm_cnt != '1))
            fmau_perf_dnorm_cnt <= fmau_perf_dnorm_cnt + 16'd1;
         if (coll && (fmau_perf_coll_cnt != '1))
            fmau_perf_coll_cnt <= fmau_perf_coll_cnt + 16'd1;
      end
   end
`endif

   assign unused_res_id             = ^res_id;
   assign fmau_fpu_ex1_cmplt        = ex1_special & vld[0] & ~hold_1;
   assign fmau_fpu_ex1_denorm_stall = dnorm_stall;
   assign fmau_pipe_vld             = vld;
   assign fmau_pipe_down            = down;
   assign fmau_fpu_result_vld       = res_vld;
   assign fmau_fpu_result_mac       = res_mac;
   assign fmau_fpu_result_id        = res_id[ID_WIDTH-1:0];
   assign fmau_busy                 = |vld[STAGES-1:1];

endmodule

// File: doc/pa_fmau_pipe_ctrl_n.md
Name: pa_fmau_pipe_ctrl_n

Overview:
- Parametrised pipeline controller for the FMAU. Successor to the fixed ex1..ex4 control path.
- Tracks per-stage valid and ID through STAGES execute stages. Retires multiply ops at MUL_LAT and multiply-add ops at MAC_LAT.
- Completes special-case operands early in ex1 and inserts a configurable denormal-normalisation stall.
- Drives the pipe-down/valid enables consumed by the FMAU datapath. Arbitrates the single result port.

Parameters:
- STAGES, 4, number of execute stages (ex1..exSTAGES); legal range 3..6
- MUL_LAT, 3, stage at which a non-mac op retires; 2 <= MUL_LAT < MAC_LAT
- MAC_LAT, 4, stage at which a mac op retires; MAC_LAT <= STAGES
- DNORM_CYC, 1, extra ex1 cycles for a denormal operand; range 1..3
- ID_WIDTH, 3, instruction ID width

Ports:
- forever_cpuclk  in  1  clock
- cpurst_b  in  1  asynchronous active-low reset
- ctrl_fmau_ex1_sel  in  1  op valid in ex1
- ex1_mac  in  1  ex1 op is multiply-add
- ex1_special  in  1  ex1 operands are special (nan/inf/zero); result formed in ex1
- ex1_denorm  in  1  ex1 operand is denormal
- ex1_id  in  ID_WIDTH  ex1 instruction ID
- rtu_xx_ex1_cancel  in  1  kill ex1 op
- ctrl_xx_ex2_cancel  in  1  kill stage-2 op
- ctrl_xx_stall  in  STAGES  external stall, bit k-1 = stage k
- fmau_fpu_ex1_cmplt  out  1  special op completes in ex1
- fmau_fpu_ex1_denorm_stall  out  1  ex1 held for normalisation
- fmau_pipe_vld  out  STAGES  stage valid, bit k-1 = stage k
- fmau_pipe_down  out  STAGES  stage k op advances this cycle
- fmau_fpu_result_vld  out  1  op retires this cycle
- fmau_fpu_result_mac  out  1  retiring op is mac
- fmau_fpu_result_id  out  ID_WIDTH  retiring op ID
- fmau_busy  out  1  OR of stage valids 2..STAGES

Behaviour:
- Reset: all stage valids 0; FSM IDLE; denorm counter 0. All outputs 0 while cpurst_b low. Reset mid-operation discards all in-flight ops without any retire.
- Stage 1 is combinational from inputs: vld[0] = sel & ~rtu_xx_ex1_cancel.
- Stages 2..STAGES are registered. Each holds valid, mac and id.
- Hold chain:
  - hold_k = ctrl_xx_stall[k-1] | hold_{k+1} | coll_k.
  - The chain propagates backward unconditionally; there is no bubble squeeze.
  - hold_1 additionally includes denorm_stall.
- Retire stage:
  - An op sitting in its retire stage (MUL_LAT if mac=0, MAC_LAT if mac=1) with hold_k=0 drives result_vld, result_mac and result_id. It then leaves the pipe; valid is cleared, not shifted.
  - A mac op passes through stage MUL_LAT normally.
- Collision:
  - Occurs when a mac retires at MAC_LAT and a non-mac occupies MUL_LAT in the same cycle.
  - The mac wins. coll_{MUL_LAT}=1, so the non-mac holds one cycle and back-pressures earlier stages.
- pipe_down[k-1] = vld[k-1] & ~hold_k & ~(retiring at k). For stage 1 it additionally requires ~ex1_special.
- Special case: ex1_special & vld[0] & ~hold_1 gives ex1_cmplt=1 and the op does not enter stage 2. Special has priority over denorm, so no stall is taken.
- Denorm FSM:
  - IDLE -> NORM when vld[0] & ex1_denorm & ~ex1_special & ~(external hold_1). Counter loads DNORM_CYC.
  - In NORM: denorm_stall=1; counter decrements on each unheld cycle; at 0, -> DONE.
  - DONE: ex1 advances when unheld, then -> IDLE.
  - rtu_xx_ex1_cancel in NORM or DONE -> IDLE and clears the counter.
  - denorm_stall is also 1 in the IDLE entry cycle.
- ctrl_xx_ex2_cancel clears stage-2 valid the same cycle. A cancelled stage-2 op produces no result and does not advance.
- Simultaneous advance-in and retire-out of one stage is legal; the incoming op is kept.

Optional Feature:
- Macro FMAU_PIPE_PERF_CNT_EN.
- With the macro: adds outputs fmau_perf_dnorm_cnt[15:0] and fmau_perf_coll_cnt[15:0].
  - These are saturating counters of denorm-stall cycles and collision cycles.
  - Reset to 0; they saturate at 16'hFFFF.
- Without the macro: no counters and no extra ports; behaviour is otherwise identical.

Decomposition:
- Package pa_fmau_pkg holds:
  - FSM state typedef (IDLE/NORM/DONE)
  - stage record typedef {vld, mac, id}
  - parameter-legality localparams
- One sub-module, pa_fmau_dnorm_fsm, holds the FSM and counter. It outputs denorm_stall and takes sel, denorm, special, cancel and ext_hold.

Test Plan:
- Non-mac op ID=5 issued, no stalls, defaults -> result_vld=1 with id=5, mac=0 exactly 2 cycles after the issue cycle (stage 3); busy is 1 for 2 cycles.
- Mac ID=2 then non-mac ID=3 on consecutive cycles -> cycle +3: result id=2, mac=1; the ID=3 op holds at stage 3; cycle +4: result id=3.
- ex1_denorm with DNORM_CYC=2 -> denorm_stall high 3 cycles; op enters stage 2 on cycle 4; result 2 cycles later.
- ex1_special & ex1_denorm -> ex1_cmplt=1 the same cycle; no stall; stage-2 valid stays 0.
- ctrl_xx_stall[2]=1 for 3 cycles with ops in stages 2 and 3 -> both hold; no result; resume retires in order. ctrl_xx_ex2_cancel in parallel with the stage-2 op -> that ID never appears.
- cpurst_b low while 3 ops are in flight -> all valids 0 and FSM IDLE; no result_vld after release.
